// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX/MEM boundary bundle: decoded operands and control in, registered EX/MEM fields and stall out.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              haveInstrIn;
    logic [DATA_W-1:0] pcIn;
    logic [DATA_W-1:0] readData1In;
    logic [DATA_W-1:0] readData2In;
    logic [DATA_W-1:0] signExtendIn;
    logic [REG_W-1:0]  rtIn;
    logic [REG_W-1:0]  rdIn;
    logic [1:0]        WBIn;
    logic [2:0]        MEMIn;
    logic              regDstIn;
    logic [1:0]        ALUOpIn;
    logic              ALUSrcIn;
    logic [1:0]        fwdA;
    logic [1:0]        fwdB;
    logic [DATA_W-1:0] memWbDataIn;

    logic              busyOut;
    logic              haveInstrOut;
    logic [DATA_W-1:0] branchTargetOut;
    logic              zeroOut;
    logic [DATA_W-1:0] aluResultOut;
    logic [DATA_W-1:0] writeDataOut;
    logic [REG_W-1:0]  writeRegOut;
    logic [1:0]        WBOut;
    logic [2:0]        MEMOut;

    modport master (
        output haveInstrIn, pcIn, readData1In, readData2In, signExtendIn, rtIn, rdIn,
               WBIn, MEMIn, regDstIn, ALUOpIn, ALUSrcIn, fwdA, fwdB, memWbDataIn,
        input  busyOut, haveInstrOut, branchTargetOut, zeroOut, aluResultOut,
               writeDataOut, writeRegOut, WBOut, MEMOut
    );

    modport slave (
        input  haveInstrIn, pcIn, readData1In, readData2In, signExtendIn, rtIn, rdIn,
               WBIn, MEMIn, regDstIn, ALUOpIn, ALUSrcIn, fwdA, fwdB, memWbDataIn,
        output busyOut, haveInstrOut, branchTargetOut, zeroOut, aluResultOut,
               writeDataOut, writeRegOut, WBOut, MEMOut
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage + EX/MEM register (falling edge); optional shift-add MUL enabled by EX_MULT_EN.
// Latency: 1 edge for ALU ops; 34 edges for MUL (bubble E0..E32, result at E33).
// Backpressure: busyOut (registered) freezes upstream while the multiplier iterates.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input logic           clk,
    input logic           reset,
    ex_mem_stage_if.slave bus
);
    logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_res, br_tgt;
    logic [5:0]        funct;
    logic [REG_W-1:0]  wreg;

    logic              have_q, have_n, zero_q, zero_n;
    logic [DATA_W-1:0] bt_q, bt_n, res_q, res_n, wd_q, wd_n;
    logic [REG_W-1:0]  wr_q, wr_n;
    logic [1:0]        wb_q, wb_n;
    logic [2:0]        mem_q, mem_n;

    // Forwarding: 10 = current EX/MEM result, 01 = MEM/WB data, 00/11 = register file
    always_comb begin
        case (bus.fwdA)
            2'b10:   op_a = res_q;
            2'b01:   op_a = bus.memWbDataIn;
            default: op_a = bus.readData1In;
        endcase
        case (bus.fwdB)
            2'b10:   fwd_b = res_q;
            2'b01:   fwd_b = bus.memWbDataIn;
            default: fwd_b = bus.readData2In;
        endcase
    end

    assign op_b   = bus.ALUSrcIn ? bus.signExtendIn : fwd_b;
    assign funct  = bus.signExtendIn[5:0];
    assign br_tgt = bus.pcIn + (bus.signExtendIn << 2);
    assign wreg   = bus.regDstIn ? bus.rdIn : bus.rtIn;

    always_comb begin
        alu_res = '0;
        case (bus.ALUOpIn)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: begin
                case (funct)
                    6'h20:   alu_res = op_a + op_b;
                    6'h22:   alu_res = op_a - op_b;
                    6'h24:   alu_res = op_a & op_b;
                    6'h25:   alu_res = op_a | op_b;
                    6'h2A:   alu_res = ($signed(op_a) < $signed(op_b)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MULT_EN
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [5:0] MUL_ITERS = 6'd32;

    state_t            state, state_n;
    logic              busy_q, busy_n, bubble, is_mul;
    logic [DATA_W-1:0] mcand_q, mcand_n, mplier_q, mplier_n, prod_q, prod_n, cap_b_q, cap_b_n;
    logic [5:0]        cnt_q, cnt_n;
    logic [REG_W-1:0]  cap_wr_q, cap_wr_n;
    logic [1:0]        cap_wb_q, cap_wb_n;
    logic [2:0]        cap_mem_q, cap_mem_n;

    assign is_mul = (bus.ALUOpIn == 2'b10) && (funct == 6'h18);
`endif

    always_comb begin
        have_n = bus.haveInstrIn;
        bt_n   = br_tgt;
        res_n  = alu_res;
        zero_n = (alu_res == '0);
        wd_n   = fwd_b;
        wr_n   = wreg;
        wb_n   = bus.WBIn;
        mem_n  = bus.MEMIn;
`ifdef EX_MULT_EN
        state_n   = state;
        busy_n    = busy_q;
        bubble    = 1'b0;
        mcand_n   = mcand_q;
        mplier_n  = mplier_q;
        prod_n    = prod_q;
        cnt_n     = cnt_q;
        cap_b_n   = cap_b_q;
        cap_wr_n  = cap_wr_q;
        cap_wb_n  = cap_wb_q;
        cap_mem_n = cap_mem_q;
        case (state)
            IDLE: begin
                if (bus.haveInstrIn && is_mul) begin
                    state_n   = BUSY;
                    busy_n    = 1'b1;
                    bubble    = 1'b1;
                    mcand_n   = op_a;
                    mplier_n  = fwd_b;
                    prod_n    = '0;
                    cnt_n     = '0;
                    cap_b_n   = fwd_b;
                    cap_wr_n  = wreg;
                    cap_wb_n  = bus.WBIn;
                    cap_mem_n = bus.MEMIn;
                end
            end
            BUSY: begin
                if (cnt_q != MUL_ITERS) begin
                    bubble   = 1'b1;
                    prod_n   = mplier_q[0] ? prod_q + mcand_q : prod_q;
                    mcand_n  = mcand_q << 1;
                    mplier_n = mplier_q >> 1;
                    cnt_n    = cnt_q + 6'd1;
                end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    have_n  = 1'b1;
                    bt_n    = '0;
                    res_n   = prod_q;
                    zero_n  = (prod_q == '0);
                    wd_n    = cap_b_q;
                    wr_n    = cap_wr_q;
                    wb_n    = cap_wb_q;
                    mem_n   = cap_mem_q;
                end
            end
            default: state_n = IDLE;
        endcase
        if (bubble) begin
            have_n = 1'b0;
            bt_n   = '0;
            res_n  = '0;
            zero_n = 1'b0;
            wd_n   = '0;
            wr_n   = '0;
            wb_n   = '0;
            mem_n  = '0;
        end
`endif
    end

`ifdef EX_MULT_EN
    always_ff @(negedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            busy_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            cap_b_q   <= '0;
            cap_wr_q  <= '0;
            cap_wb_q  <= '0;
            cap_mem_q <= '0;
        end else begin
            busy_q    <= busy_n;
            mcand_q   <= mcand_n;
            mplier_q  <= mplier_n;
            prod_q    <= prod_n;
            cnt_q     <= cnt_n;
            cap_b_q   <= cap_b_n;
            cap_wr_q  <= cap_wr_n;
            cap_wb_q  <= cap_wb_n;
            cap_mem_q <= cap_mem_n;
        end
    end

    assign bus.busyOut = busy_q;
`else
    assign bus.busyOut = 1'b0;
`endif

    always_ff @(negedge clk) begin
        if (reset) begin
            have_q <= 1'b0;
            bt_q   <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            wd_q   <= '0;
            wr_q   <= '0;
            wb_q   <= '0;
            mem_q  <= '0;
        end else begin
            have_q <= have_n;
            bt_q   <= bt_n;
            res_q  <= res_n;
            zero_q <= zero_n;
            wd_q   <= wd_n;
            wr_q   <= wr_n;
            wb_q   <= wb_n;
            mem_q  <= mem_n;
        end
    end

    assign bus.haveInstrOut    = have_q;
    assign bus.branchTargetOut = bt_q;
    assign bus.zeroOut         = zero_q;
    assign bus.aluResultOut    = res_q;
    assign bus.writeDataOut    = wd_q;
    assign bus.writeRegOut     = wr_q;
    assign bus.WBOut           = wb_q;
    assign bus.MEMOut          = mem_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: vector table, randomized model comparison, MUL/reset sequences.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_W(32), .REG_W(5)) bus ();
    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        have;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rt, rd;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic        regdst;
        logic [1:0]  op;
        logic        src;
        logic [1:0]  fa, fb;
        logic [31:0] mwb;
    } in_t;

    typedef struct packed {
        logic        busy, have;
        logic [31:0] bt;
        logic        zero;
        logic [31:0] res, wd;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic [2:0]  mem;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    int tests = 0;
    int fails = 0;
    logic [31:0] prev_res = '0;

    task automatic drive(input in_t v);
        bus.haveInstrIn  = v.have;
        bus.pcIn         = v.pc;
        bus.readData1In  = v.a;
        bus.readData2In  = v.b;
        bus.signExtendIn = v.imm;
        bus.rtIn         = v.rt;
        bus.rdIn         = v.rd;
        bus.WBIn         = v.wb;
        bus.MEMIn        = v.mem;
        bus.regDstIn     = v.regdst;
        bus.ALUOpIn      = v.op;
        bus.ALUSrcIn     = v.src;
        bus.fwdA         = v.fa;
        bus.fwdB         = v.fb;
        bus.memWbDataIn  = v.mwb;
    endtask

    // DUT registers on the falling edge; outputs are sampled and inputs changed on the rising edge
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = '{busy: bus.busyOut, have: bus.haveInstrOut, bt: bus.branchTargetOut,
                zero: bus.zeroOut, res: bus.aluResultOut, wd: bus.writeDataOut,
                wr: bus.writeRegOut, wb: bus.WBOut, mem: bus.MEMOut};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got busy=%b have=%b bt=%h zero=%b res=%h wd=%h wr=%0d wb=%b mem=%b, expected busy=%b have=%b bt=%h zero=%b res=%h wd=%h wr=%0d wb=%b mem=%b",
                     name, act.busy, act.have, act.bt, act.zero, act.res, act.wd, act.wr, act.wb, act.mem,
                     exp.busy, exp.have, exp.bt, exp.zero, exp.res, exp.wd, exp.wr, exp.wb, exp.mem);
        end
        prev_res = exp.res;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv,
                                         input logic [31:0] mwb, input logic [31:0] prev);
        if (sel == 2'b10) return prev;
        if (sel == 2'b01) return mwb;
        return regv;
    endfunction

    // Reference for single-cycle instructions, straight from the ISA rules
    function automatic out_t model(input in_t v, input logic [31:0] prev);
        logic [31:0] a, bf, bb, r;
        int sa, sb;
        out_t o;
        a  = pick(v.fa, v.a, v.mwb, prev);
        bf = pick(v.fb, v.b, v.mwb, prev);
        bb = v.src ? v.imm : bf;
        sa = a;
        sb = bb;
        r  = 32'h0;
        if (v.op == 2'b00) r = a + bb;
        else if (v.op == 2'b01) r = a - bb;
        else if (v.op == 2'b10) begin
            if (v.imm[5:0] == 6'h20) r = a + bb;
            else if (v.imm[5:0] == 6'h22) r = a - bb;
            else if (v.imm[5:0] == 6'h24) r = a & bb;
            else if (v.imm[5:0] == 6'h25) r = a | bb;
            else if (v.imm[5:0] == 6'h2A) r = (sa < sb) ? 32'd1 : 32'd0;
        end
        o = '{busy: 1'b0, have: v.have, bt: v.pc + v.imm * 4, zero: (r == 32'h0), res: r,
              wd: bf, wr: v.regdst ? v.rd : v.rt, wb: v.wb, mem: v.mem};
        return o;
    endfunction

    vec_t tbl[11];
    in_t  m, nx, rv;
    out_t z, e;
    logic [31:0] r1, r2;
    logic [5:0]  f;

    initial begin
        // fields: have pc a b imm rt rd wb mem regdst op src fa fb mwb | busy have bt zero res wd wr wb mem
        tbl[0]  = '{'{1'b1, 32'h0,   32'd5,      32'd5,      32'h22,       5'd3, 5'd9,  2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 32'h0},
                    '{1'b0, 1'b1, 32'h88, 1'b1, 32'h0,        32'd5,      5'd9,  2'b10, 3'b000}};
        tbl[1]  = '{'{1'b1, 32'h40,  32'd8,      32'd8,      32'h20,       5'd2, 5'd5,  2'b01, 3'b000, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 32'h0},
                    '{1'b0, 1'b1, 32'hC0, 1'b0, 32'h10,       32'd8,      5'd5,  2'b01, 3'b000}};
        tbl[2]  = '{'{1'b1, 32'h44,  32'h99,     32'h77,     32'h4,        5'd7, 5'd0,  2'b11, 3'b010, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 32'h0},
                    '{1'b0, 1'b1, 32'h54, 1'b0, 32'h14,       32'h77,     5'd7,  2'b11, 3'b010}};
        tbl[3]  = '{'{1'b1, 32'h0,   32'h1,      32'h0,      32'h0,        5'd2, 5'd0,  2'b01, 3'b001, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 32'hAB},
                    '{1'b0, 1'b1, 32'h0,  1'b0, 32'h1,        32'hAB,     5'd2,  2'b01, 3'b001}};
        tbl[4]  = '{'{1'b1, 32'h100, 32'd3,      32'd3,      32'hFFFFFFFE, 5'd4, 5'd0,  2'b00, 3'b100, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h0},
                    '{1'b0, 1'b1, 32'hF8, 1'b1, 32'h0,        32'd3,      5'd4,  2'b00, 3'b100}};
        tbl[5]  = '{'{1'b1, 32'h0,   32'hFFFFFFFF, 32'd1,    32'h2A,       5'd0, 5'd10, 2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 32'h0},
                    '{1'b0, 1'b1, 32'hA8, 1'b0, 32'h1,        32'd1,      5'd10, 2'b10, 3'b000}};
        tbl[6]  = '{'{1'b0, 32'h0,   32'hF0F0,   32'hFF00,   32'h24,       5'd0, 5'd1,  2'b11, 3'b111, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 32'h0},
                    '{1'b0, 1'b0, 32'h90, 1'b0, 32'hF000,     32'hFF00,   5'd1,  2'b11, 3'b111}};
        tbl[7]  = '{'{1'b1, 32'h0,   32'hF0,     32'h0F,     32'h25,       5'd0, 5'd3,  2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 2'b11, 2'b11, 32'hDEAD},
                    '{1'b0, 1'b1, 32'h94, 1'b0, 32'hFF,       32'h0F,     5'd3,  2'b10, 3'b000}};
        tbl[8]  = '{'{1'b1, 32'h4,   32'd1,      32'd2,      32'h0,        5'd6, 5'd0,  2'b10, 3'b000, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 32'h0},
                    '{1'b0, 1'b1, 32'h4,  1'b1, 32'h0,        32'd2,      5'd6,  2'b10, 3'b000}};
        tbl[9]  = '{'{1'b1, 32'h0,   32'd5,      32'd6,      32'h27,       5'd0, 5'd7,  2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 32'h0},
                    '{1'b0, 1'b1, 32'h9C, 1'b1, 32'h0,        32'd6,      5'd7,  2'b10, 3'b000}};
        tbl[10] = '{'{1'b1, 32'h0,   32'd0,      32'd1,      32'h22,       5'd0, 5'd8,  2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 32'h0},
                    '{1'b0, 1'b1, 32'h88, 1'b0, 32'hFFFFFFFF, 32'd1,      5'd8,  2'b10, 3'b000}};

        z = '0;
        m  = '{have: 1'b1, pc: 32'h0, a: 32'hFFFF, b: 32'h10001, imm: 32'h18, rt: 5'd0, rd: 5'd4,
               wb: 2'b10, mem: 3'b001, regdst: 1'b1, op: 2'b10, src: 1'b0, fa: 2'b00, fb: 2'b00, mwb: 32'h0};
        nx = '{have: 1'b1, pc: 32'h0, a: 32'd2, b: 32'd3, imm: 32'h20, rt: 5'd0, rd: 5'd6,
               wb: 2'b01, mem: 3'b000, regdst: 1'b1, op: 2'b10, src: 1'b0, fa: 2'b00, fb: 2'b00, mwb: 32'h0};

        reset = 1'b1;
        drive('0);
        @(posedge clk);
        tick();
        tick();
        check("reset", z);

        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].i);
            tick();
            check($sformatf("vec%0d", i), tbl[i].o);
        end

        for (int i = 0; i < 300; i++) begin
            r1 = $urandom();
            r2 = $urandom();
            case ($urandom_range(0, 7))
                0: f = 6'h20;
                1: f = 6'h22;
                2: f = 6'h24;
                3: f = 6'h25;
                4: f = 6'h2A;
                5: f = 6'h18;
                6: f = r1[5:0];
                default: f = 6'h27;
            endcase
            rv.have   = $urandom_range(0, 3) != 0;
            rv.pc     = $urandom();
            rv.a      = $urandom();
            rv.b      = ($urandom_range(0, 3) == 0) ? rv.a : $urandom();
            rv.imm    = {r2[31:6], f};
            rv.rt     = 5'($urandom_range(0, 31));
            rv.rd     = 5'($urandom_range(0, 31));
            rv.wb     = 2'($urandom_range(0, 3));
            rv.mem    = 3'($urandom_range(0, 7));
            rv.regdst = 1'($urandom_range(0, 1));
            rv.op     = 2'($urandom_range(0, 3));
            rv.src    = 1'($urandom_range(0, 1));
            rv.fa     = 2'($urandom_range(0, 3));
            rv.fb     = 2'($urandom_range(0, 3));
            rv.mwb    = $urandom();
`ifdef EX_MULT_EN
            if (rv.op == 2'b10 && f == 6'h18) rv.imm[5:0] = 6'h20;
`endif
            drive(rv);
            tick();
            check($sformatf("rand%0d", i), model(rv, prev_res));
        end

`ifdef EX_MULT_EN
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                m.a = $urandom();
                m.b = (k == 3) ? 32'h0 : $urandom();
            end
            drive(m);
            tick();
            e = z;
            e.busy = 1'b1;
            check($sformatf("mul%0d_e0", k), e);
            drive(nx);
            for (int j = 1; j <= 32; j++) begin
                tick();
                if (k == 0 || j == 32) check($sformatf("mul%0d_e%0d", k, j), e);
            end
            tick();
            e = '{busy: 1'b0, have: 1'b1, bt: 32'h0, zero: (m.a * m.b) == 32'h0, res: m.a * m.b,
                  wd: m.b, wr: 5'd4, wb: 2'b10, mem: 3'b001};
            check($sformatf("mul%0d_e33", k), e);
            tick();
            check($sformatf("mul%0d_e34", k), model(nx, prev_res));
        end

        m.a = 32'hFFFF;
        m.b = 32'h10001;
        drive(m);
        tick();
        drive(nx);
        repeat (9) tick();
        e = z;
        e.busy = 1'b1;
        check("mul_e9_busy", e);
        reset = 1'b1;
        tick();
        check("mul_reset_e10", z);
        reset = 1'b0;
        tick();
        check("add_after_reset", model(nx, prev_res));
        tick();
        check("no_restart", model(nx, prev_res));
`else
        drive(m);
        tick();
        check("mul_disabled", model(m, prev_res));
        drive(nx);
        tick();
        check("after_mul_disabled", model(nx, prev_res));
        reset = 1'b1;
        tick();
        check("reset_again", z);
        reset = 1'b0;
        tick();
        check("add_after_reset", model(nx, prev_res));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
